// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment capture block:
// hex glyph patterns (bit0=a .. bit6=g, bit7=dp) and the capture FSM states.
package seven_seg_pkg;

  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h6F;
  localparam logic [7:0] GLYPH_A = 8'h77;
  localparam logic [7:0] GLYPH_B = 8'h7C;
  localparam logic [7:0] GLYPH_C = 8'h39;
  localparam logic [7:0] GLYPH_D = 8'h5E;
  localparam logic [7:0] GLYPH_E = 8'h79;
  localparam logic [7:0] GLYPH_F = 8'h71;

  // Decimal point segment; any pattern with it lit is not a hex glyph.
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    EMIT   = 2'd1,
    HOLD   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Segment-bus monitor port plus decoded-value valid/ready handoff.
interface seven_seg_capture_if;

  logic [7:0] SevenSegDig1;
  logic [7:0] SevenSegDig2;
  logic       Ready;
  logic [7:0] Value;
  logic       ValueValid;
  logic       DecodeError;

  modport master (
    output SevenSegDig1,
    output SevenSegDig2,
    output Ready,
    input  Value,
    input  ValueValid,
    input  DecodeError
  );

  modport slave (
    input  SevenSegDig1,
    input  SevenSegDig2,
    input  Ready,
    output Value,
    output ValueValid,
    output DecodeError
  );

endinterface

// File: rtl/seven_seg_to_hex.sv
// Combinational reverse glyph lookup: segment pattern to hex nibble.
// legal is low for any non-glyph pattern, including anything with dp lit.
module seven_seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  // Pattern decode; unmatched patterns fall through to illegal.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    if (pattern[SEG_DP]) begin
      nibble = 4'h0;
      legal  = 1'b0;
    end else begin
      legal = 1'b1;
      case (pattern)
        GLYPH_0: nibble = 4'h0;
        GLYPH_1: nibble = 4'h1;
        GLYPH_2: nibble = 4'h2;
        GLYPH_3: nibble = 4'h3;
        GLYPH_4: nibble = 4'h4;
        GLYPH_5: nibble = 4'h5;
        GLYPH_6: nibble = 4'h6;
        GLYPH_7: nibble = 4'h7;
        GLYPH_8: nibble = 4'h8;
        GLYPH_9: nibble = 4'h9;
        GLYPH_A: nibble = 4'hA;
        GLYPH_B: nibble = 4'hB;
        GLYPH_C: nibble = 4'hC;
        GLYPH_D: nibble = 4'hD;
        GLYPH_E: nibble = 4'hE;
        GLYPH_F: nibble = 4'hF;
        default: begin
          nibble = 4'h0;
          legal  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Watches the two digit buses, waits for a stable pair, decodes it and
// reports each new stable value once (or flags it if it is not hex).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  seven_seg_capture_if.slave  cap
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_THR  = CW'(STABLE_CYCLES - 1);

  cap_state_e    state_r, state_nxt_s;
  logic [15:0]   pair_s;
  logic [15:0]   sample_r;
  logic [15:0]   last_r;
  logic          last_valid_r;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          same_s;
  logic          accept_s;
  logic [3:0]    nib_hi_s, nib_lo_s;
  logic          legal_hi_s, legal_lo_s;
  logic [7:0]    value_r;
  logic          valid_r, valid_nxt_s;
  logic          err_r, err_set_s;
  logic          load_value_s;
  logic          take_last_s;

  assign pair_s = {cap.SevenSegDig1, cap.SevenSegDig2};
  assign same_s = (pair_s == sample_r);

  seven_seg_to_hex u_dec_hi (
    .pattern (sample_r[15:8]),
    .nibble  (nib_hi_s),
    .legal   (legal_hi_s)
  );

  seven_seg_to_hex u_dec_lo (
    .pattern (sample_r[7:0]),
    .nibble  (nib_lo_s),
    .legal   (legal_lo_s)
  );

  // Stability count that the sample will hold after this edge.
  always_comb begin
    cnt_nxt_s = CNT_ZERO;
    if (!same_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_SAT) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // The edge that completes STABLE_CYCLES stable samples accepts a pair
  // that has not already been reported since reset.
  assign accept_s = same_s && (cnt_nxt_s >= CNT_THR) &&
                    (!last_valid_r || (sample_r != last_r));

  // Next-state and action decode for the capture FSM.
  always_comb begin
    state_nxt_s  = state_r;
    valid_nxt_s  = valid_r;
    load_value_s = 1'b0;
    err_set_s    = 1'b0;
    take_last_s  = 1'b0;
    case (state_r)
      SETTLE: begin
        if (accept_s) begin
          take_last_s = 1'b1;
          if (legal_hi_s && legal_lo_s) begin
            load_value_s = 1'b1;
            valid_nxt_s  = 1'b1;
            state_nxt_s  = EMIT;
          end else begin
            err_set_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      EMIT: begin
        if (cap.Ready) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      HOLD: begin
        if (!same_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = SETTLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= SETTLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input sampling and stability counting run in every state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sample_r <= 16'h0000;
      cnt_r    <= CNT_ZERO;
    end else begin
      sample_r <= pair_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Last-reported pair, so a held pair is never reported twice.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_r       <= 16'h0000;
      last_valid_r <= 1'b0;
    end else if (take_last_s) begin
      last_r       <= sample_r;
      last_valid_r <= 1'b1;
    end else begin
      last_r       <= last_r;
      last_valid_r <= last_valid_r;
    end
  end

  // Output registers; Value only moves on a fresh legal acceptance.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      value_r <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (load_value_s) begin
        value_r <= {nib_hi_s, nib_lo_s};
      end else begin
        value_r <= value_r;
      end
      valid_r <= valid_nxt_s;
      err_r   <= err_set_s;
    end
  end

  assign cap.Value       = value_r;
  assign cap.ValueValid  = valid_r;
  assign cap.DecodeError = err_r;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: two builds (STABLE_CYCLES 4 and 2),
// expected reports queued on stimulus and popped as the DUTs hand them off.
module tb_seven_seg_capture;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  seven_seg_capture_if ifa ();
  seven_seg_capture_if ifb ();

  seven_seg_capture #(.STABLE_CYCLES(4)) dut_a (
    .Clock   (clk),
    .Reset_n (rst_n),
    .cap     (ifa)
  );

  seven_seg_capture #(.STABLE_CYCLES(2)) dut_b (
    .Clock   (clk),
    .Reset_n (rst_b_n),
    .cap     (ifb)
  );

  // Queue entries are {decode_error, value}.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic e, input logic v, input logic [7:0] val);
    chk(tag, {6'b0, ifa.DecodeError, ifa.ValueValid, ifa.Value}, {6'b0, e, v, val});
  endtask

  task automatic chk_b(input string tag, input logic e, input logic v, input logic [7:0] val);
    chk(tag, {6'b0, ifb.DecodeError, ifb.ValueValid, ifb.Value}, {6'b0, e, v, val});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_a(input logic [7:0] d1, input logic [7:0] d2);
    ifa.SevenSegDig1 = d1;
    ifa.SevenSegDig2 = d2;
  endtask

  task automatic set_b(input logic [7:0] d1, input logic [7:0] d2);
    ifb.SevenSegDig1 = d1;
    ifb.SevenSegDig2 = d2;
  endtask

  // Scoreboard for build A: every handshake or error pulse consumes one entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((ifa.ValueValid && ifa.Ready) || ifa.DecodeError) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_report", 16'(qa.size()), 16'd1);
        end else begin
          chk("a_report", {7'b0, ifa.DecodeError, (ifa.DecodeError ? 8'h00 : ifa.Value)},
              {7'b0, qa.pop_front()});
        end
      end
    end
  end

  // Scoreboard for build B.
  always @(negedge clk) begin
    if (rst_b_n) begin
      if ((ifb.ValueValid && ifb.Ready) || ifb.DecodeError) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_report", 16'(qb.size()), 16'd1);
        end else begin
          chk("b_report", {7'b0, ifb.DecodeError, (ifb.DecodeError ? 8'h00 : ifb.Value)},
              {7'b0, qb.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    rst_b_n   = 1'b0;
    ifa.Ready = 1'b0;
    ifb.Ready = 1'b1;
    set_a(8'h07, 8'h71);
    set_b(8'h7C, 8'h5E);
    tick(2);
    chk_a("reset_a", 1'b0, 1'b0, 8'h00);
    chk_b("reset_b", 1'b0, 1'b0, 8'h00);

    // 07/71 -> 7F, four stable edges after release, reported once.
    qa.push_back({1'b0, 8'h7F});
    qb.push_back({1'b0, 8'hBD});
    ifa.Ready = 1'b1;
    rst_n     = 1'b1;
    rst_b_n   = 1'b1;
    tick(3);
    chk_a("latency_k2", 1'b0, 1'b0, 8'h00);
    tick(1);
    chk_a("latency_k3", 1'b0, 1'b1, 8'h7F);
    tick(1);
    chk_a("one_shot", 1'b0, 1'b0, 8'h7F);
    tick(10);
    chk_a("held_no_repeat", 1'b0, 1'b0, 8'h7F);

    // Backpressure: 01 frozen while the bus moves on to 23.
    ifa.Ready = 1'b0;
    set_a(8'h3F, 8'h06);
    qa.push_back({1'b0, 8'h01});
    tick(4);
    chk_a("emit_01", 1'b0, 1'b1, 8'h01);
    set_a(8'h5B, 8'h4F);
    qa.push_back({1'b0, 8'h23});
    tick(8);
    chk_a("frozen_01", 1'b0, 1'b1, 8'h01);
    ifa.Ready = 1'b1;
    tick(1);
    chk_a("handshake_drop", 1'b0, 1'b0, 8'h01);
    tick(1);
    chk_a("next_edge_23", 1'b0, 1'b1, 8'h23);
    tick(1);
    chk_a("drop_23", 1'b0, 1'b0, 8'h23);

    // Short glitch to 88 inside a stable 11 stream is ignored.
    set_a(8'h06, 8'h06);
    qa.push_back({1'b0, 8'h11});
    tick(4);
    chk_a("report_11", 1'b0, 1'b1, 8'h11);
    tick(3);
    set_a(8'h7F, 8'h7F);
    tick(2);
    chk_a("glitch_quiet", 1'b0, 1'b0, 8'h11);
    set_a(8'h06, 8'h06);
    tick(10);
    chk_a("after_glitch", 1'b0, 1'b0, 8'h11);

    // dp-only high digit: single error pulse, no valid, no repeat.
    set_a(8'h80, 8'h3F);
    qa.push_back({1'b1, 8'h00});
    tick(3);
    chk_a("err_pre", 1'b0, 1'b0, 8'h11);
    tick(1);
    chk_a("err_pulse", 1'b1, 1'b0, 8'h11);
    tick(1);
    chk_a("err_end", 1'b0, 1'b0, 8'h11);
    tick(10);
    chk_a("err_hold", 1'b0, 1'b0, 8'h11);

    // A5 reported, reset mid-stream, reported again after release.
    set_a(8'h77, 8'h6D);
    qa.push_back({1'b0, 8'hA5});
    tick(4);
    chk_a("report_a5", 1'b0, 1'b1, 8'hA5);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_a("in_reset", 1'b0, 1'b0, 8'h00);
    tick(2);
    chk_a("in_reset_hold", 1'b0, 1'b0, 8'h00);
    qa.push_back({1'b0, 8'hA5});
    rst_n = 1'b1;
    tick(3);
    chk_a("post_rst_k2", 1'b0, 1'b0, 8'h00);
    tick(1);
    chk_a("post_rst_a5", 1'b0, 1'b1, 8'hA5);
    tick(2);

    // STABLE_CYCLES=2 build: toggle every two cycles, each change reported.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] exp_v;
      if ((i % 2) == 0) begin
        set_b(8'h39, 8'h79);
        exp_v = 8'hCE;
      end else begin
        set_b(8'h7C, 8'h5E);
        exp_v = 8'hBD;
      end
      qb.push_back({1'b0, exp_v});
      tick(2);
      chk_b("toggle", 1'b0, 1'b1, exp_v);
    end
    tick(4);
    chk_b("toggle_idle", 1'b0, 1'b0, 8'hBD);

    chk("qa_drained", 16'(qa.size()), 16'd0);
    chk("qb_drained", 16'(qb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
